// File: rtl/fm_radio_pkg.sv
// Shared FM radio chain definitions: sample widths, quantizer shift, read_iq state
// encoding and the fixed-point quantizer used by every stage that converts 16-bit samples.
package fm_radio_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int BITS       = 10;

    typedef enum logic [2:0] {
        S_I0    = 3'd0,
        S_I1    = 3'd1,
        S_Q0    = 3'd2,
        S_Q1    = 3'd3,
        S_WRITE = 3'd4
    } read_iq_state_t;

    // Sign-extend to the datapath width first so the shift keeps the sign bit.
    function automatic logic signed [DATA_WIDTH-1:0] quantize(input logic signed [15:0] sample);
        logic signed [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'(sample);
        return ext <<< BITS;
    endfunction

endpackage

// File: rtl/read_iq_if.sv
// FIFO-side signals of read_iq: input byte FIFO read port and output {I,Q} FIFO write port.
// master is the unpacker, slave is the FIFO pair around it.
interface read_iq_if;
    import fm_radio_pkg::*;

    logic [BYTE_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] out_i;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_full;
    logic                  out_wr_en;

    modport master (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_i, out_q, out_wr_en
    );

    modport slave (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_i, out_q, out_wr_en
    );

endinterface

// File: rtl/read_iq.sv
// Byte-to-I/Q unpacker: pops four little-endian bytes per pair, quantizes I and Q
// and pushes one registered {I,Q} pair into the output FIFO.
//
// state   | meaning
// S_I0    | waiting for I low byte
// S_I1    | waiting for I high byte
// S_Q0    | waiting for Q low byte
// S_Q1    | waiting for Q high byte; capture quantizes the full pair
// S_WRITE | pair held on out_i/out_q until the output FIFO accepts it
module read_iq
    import fm_radio_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    read_iq_if.master bus
);

    read_iq_state_t state_q, state_d;

    logic [BYTE_WIDTH-1:0] i_lo_q, i_lo_d;
    logic [BYTE_WIDTH-1:0] i_hi_q, i_hi_d;
    logic [BYTE_WIDTH-1:0] q_lo_q, q_lo_d;
    logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
    logic [DATA_WIDTH-1:0] out_q_q, out_q_d;
    logic                  rd_en;
    logic                  wr_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_I0;
            i_lo_q  <= '0;
            i_hi_q  <= '0;
            q_lo_q  <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
        end else begin
            state_q <= state_d;
            i_lo_q  <= i_lo_d;
            i_hi_q  <= i_hi_d;
            q_lo_q  <= q_lo_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_lo_d  = i_lo_q;
        i_hi_d  = i_hi_q;
        q_lo_d  = q_lo_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            S_I0: begin
                rd_en = !bus.in_empty;
                if (rd_en) begin
                    i_lo_d  = bus.in_dout;
                    state_d = S_I1;
                end
            end
            S_I1: begin
                rd_en = !bus.in_empty;
                if (rd_en) begin
                    i_hi_d  = bus.in_dout;
                    state_d = S_Q0;
                end
            end
            S_Q0: begin
                rd_en = !bus.in_empty;
                if (rd_en) begin
                    q_lo_d  = bus.in_dout;
                    state_d = S_Q1;
                end
            end
            S_Q1: begin
                rd_en = !bus.in_empty;
                // Q high byte is never stored; it feeds the quantizer on the capture edge.
                if (rd_en) begin
                    out_i_d = quantize({i_hi_q, i_lo_q});
                    out_q_d = quantize({bus.in_dout, q_lo_q});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en = !bus.out_full;
                if (wr_en) begin
                    state_d = S_I0;
                end
            end
            default: begin
                state_d = S_I0;
            end
        endcase
    end

    assign bus.in_rd_en  = rd_en;
    assign bus.out_wr_en = wr_en;
    assign bus.out_i     = out_i_q;
    assign bus.out_q     = out_q_q;

endmodule

// File: tb/tb_read_iq.sv
// Scoreboard bench for read_iq: a byte-queue FIFO model feeds the DUT, expected pairs
// are queued at stimulus time and a monitor compares every output write.
module tb_read_iq;
    import fm_radio_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    read_iq_if bus();

    read_iq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  src_q[$];
    logic [63:0] exp_q[$];
    int          write_count = 0;
    int          cycle = 0;
    int          last_write_cycle = -1;
    bit          rate_check = 0;
    bit          stall_toggle = 0;
    bit          stall_in = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] v);
        longint x;
        x = longint'($signed(v)) * 1024;
        return x[31:0];
    endfunction

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        src_q.push_back(b0);
        src_q.push_back(b1);
        src_q.push_back(b2);
        src_q.push_back(b3);
    endtask

    task automatic send_directed(input logic [31:0] v, input logic [31:0] ei, input logic [31:0] eq);
        push_bytes(v[31:24], v[23:16], v[15:8], v[7:0]);
        exp_q.push_back({ei, eq});
    endtask

    task automatic send_pair(input logic [15:0] i, input logic [15:0] q);
        push_bytes(i[7:0], i[15:8], q[7:0], q[15:8]);
        exp_q.push_back({model(i), model(q)});
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (write_count < target && n < budget) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        chk("write_count", write_count, target);
    endtask

    always @(posedge clock) cycle++;

    // Input FIFO model: first-word-fall-through, pops on a sampled read enable.
    initial begin
        bit pop;
        bus.in_empty = 1'b1;
        bus.in_dout  = 8'h00;
        forever begin
            @(negedge clock);
            pop = bus.in_rd_en && !bus.in_empty && reset;
            @(posedge clock);
            #1;
            if (pop && src_q.size() > 0) void'(src_q.pop_front());
            stall_in     = stall_toggle ? !stall_in : 1'b0;
            bus.in_empty = (src_q.size() == 0) || stall_in;
            bus.in_dout  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    always @(negedge clock) begin
        if (reset && bus.out_wr_en) begin
            logic [63:0] e;
            write_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h_%h required=no_write", bus.out_i, bus.out_q);
            end else begin
                e = exp_q.pop_front();
                chk("pair_i", bus.out_i, e[63:32]);
                chk("pair_q", bus.out_q, e[31:0]);
            end
            if (rate_check && last_write_cycle >= 0)
                chk("write_interval", cycle - last_write_cycle, 5);
            last_write_cycle = cycle;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        bus.out_full = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_out_i", bus.out_i, 32'h0);
        chk("reset_out_q", bus.out_q, 32'h0);
        chk("reset_wr_en", 32'(bus.out_wr_en), 32'h0);
        chk("reset_rd_en", 32'(bus.in_rd_en), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        send_directed(32'h3412CDAB, 32'h0048D000, 32'hFEAF3400);
        send_directed(32'h0080FF7F, 32'hFE000000, 32'h01FFFC00);
        wait_writes(2, 60);

        // Continuous stream: one pair every 5 cycles.
        repeat (3) @(posedge clock);
        #1;
        last_write_cycle = -1;
        rate_check = 1;
        for (int k = 0; k < 100; k++)
            send_pair(16'(k * 331 - 16000), 16'(30000 - k * 977));
        wait_writes(102, 700);
        rate_check = 0;

        // Output stall held while the next pair's bytes are already waiting.
        @(posedge clock);
        #1 bus.out_full = 1'b1;
        send_pair(16'h7FFF, 16'h8001);
        send_pair(16'h0001, 16'hFFFF);
        n = 0;
        while (src_q.size() > 4 && n < 50) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("stall_rd_en", 32'(bus.in_rd_en), 32'h0);
            chk("stall_wr_en", 32'(bus.out_wr_en), 32'h0);
            chk("stall_out_i", bus.out_i, 32'h01FFFC00);
            chk("stall_out_q", bus.out_q, 32'hFE000400);
        end
        @(posedge clock);
        #1 bus.out_full = 1'b0;
        wait_writes(104, 60);

        // Input FIFO flickering empty every other cycle.
        stall_toggle = 1;
        send_directed(32'h3412CDAB, 32'h0048D000, 32'hFEAF3400);
        send_directed(32'h0080FF7F, 32'hFE000000, 32'h01FFFC00);
        send_pair(16'h0005, 16'hFFFB);
        wait_writes(107, 120);
        stall_toggle = 0;

        // Reset after two bytes of a pair: partial pair discarded.
        base = write_count;
        src_q.push_back(8'h55);
        src_q.push_back(8'h66);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        src_q.delete();
        @(negedge clock);
        chk("midreset_out_i", bus.out_i, 32'h0);
        chk("midreset_out_q", bus.out_q, 32'h0);
        chk("midreset_wr_en", 32'(bus.out_wr_en), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        send_directed(32'h01000200, 32'h00000400, 32'h00000800);
        wait_writes(base + 1, 60);
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("no_extra_write", write_count, base + 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
